// File: rtl/dram_pkg.sv
// Shared state encoding and default timing values for the DRAM command sequencer.
package dram_pkg;

   typedef enum logic [2:0] {
      POWER_UP  = 3'd0,
      IDLE      = 3'd1,
      ACTIVATE  = 3'd2,
      READ      = 3'd3,
      WRITE     = 3'd4,
      PRECHARGE = 3'd5,
      PRE_ALL   = 3'd6,
      REFRESH   = 3'd7
   } dram_state_t;

   localparam int unsigned T_INIT_DEF = 200;
   localparam int unsigned T_RCD_DEF  = 3;
   localparam int unsigned T_RP_DEF   = 3;
   localparam int unsigned T_CL_DEF   = 4;
   localparam int unsigned T_WR_DEF   = 4;
   localparam int unsigned T_RFC_DEF  = 16;

   function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank open-page table: open flag plus open row, with hit lookup for the requested bank.
module dram_bank_tracker
   import dram_pkg::*;
#(
   parameter int unsigned NBANK = 4,
   parameter int unsigned ROW_W = 14
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(NBANK)-1:0] lookBank,
   input  logic [ROW_W-1:0]         lookRow,
   input  logic [$clog2(NBANK)-1:0] setBank,
   input  logic                     openEn,
   input  logic                     closeEn,
   input  logic                     clearAll,
   output logic                     bankOpen_c,
   output logic                     rowHit_c,
   output logic                     anyOpen_c
);

   logic [NBANK-1:0] openFlag;
   logic [ROW_W-1:0] openRow [NBANK];

   // Flag/row update; clearAll wins over single-bank updates
   always_ff @(posedge clk) begin
      if (rst) begin
         openFlag <= '0;
         for (int i = 0; i < int'(NBANK); i++) openRow[i] <= '0;
      end else if (clearAll) begin
         openFlag <= '0;
      end else begin
         if (openEn) begin
            openFlag[setBank] <= 1'b1;
            openRow[setBank]  <= lookRow;
         end
         if (closeEn) openFlag[setBank] <= 1'b0;
      end
   end

   assign bankOpen_c = openFlag[lookBank];
   assign rowHit_c   = (openRow[lookBank] == lookRow);
   assign anyOpen_c  = |openFlag;

endmodule

// File: rtl/dram_cmd_fsm_mb.sv
// DRAM command sequencer: power-up wait, open-page access with activate/precharge,
// and refresh with precharge-all. Timing driven by a single down-counter.
module dram_cmd_fsm_mb
   import dram_pkg::*;
#(
   parameter int unsigned NBANK  = 4,
   parameter int unsigned ROW_W  = 14,
   parameter int unsigned T_INIT = T_INIT_DEF,
   parameter int unsigned T_RCD  = T_RCD_DEF,
   parameter int unsigned T_RP   = T_RP_DEF,
   parameter int unsigned T_CL   = T_CL_DEF,
   parameter int unsigned T_WR   = T_WR_DEF,
   parameter int unsigned T_RFC  = T_RFC_DEF
)(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     dREN,
   input  logic                     dWEN,
   input  logic [$clog2(NBANK)-1:0] req_bank,
   input  logic [ROW_W-1:0]         req_row,
   input  logic                     rf_req,
   output dram_state_t              cmd_state,
   output dram_state_t              ncmd_state,
   output logic [$clog2(NBANK)-1:0] cmd_bank,
   output logic                     init_done,
   output logic                     row_resolve,
   output logic                     ram_wait
);

   localparam int unsigned T_MAX = maxU(maxU(maxU(T_INIT, T_RCD), maxU(T_RP, T_CL)),
                                        maxU(T_WR, T_RFC));
   localparam int unsigned CNT_W = $clog2(T_MAX + 1);

   logic [CNT_W-1:0] tcnt;
   logic [CNT_W-1:0] tload;
   logic             tdone;
   logic             accessRd;
   logic             startAccess;
   logic             startRefresh;
   logic             openEn;
   logic             closeEn;
   logic             clearAll;
   logic             bankOpen_c;
   logic             rowHit_c;
   logic             anyOpen_c;

   assign tdone    = (tcnt == CNT_W'(1));
   assign clearAll = (cmd_state == PRE_ALL) || (cmd_state == REFRESH);

   dram_bank_tracker #(
      .NBANK (NBANK),
      .ROW_W (ROW_W)
   ) uTracker (
      .clk        (CLK),
      .rst        (RST),
      .lookBank   (req_bank),
      .lookRow    (req_row),
      .setBank    (cmd_bank),
      .openEn     (openEn),
      .closeEn    (closeEn),
      .clearAll   (clearAll),
      .bankOpen_c (bankOpen_c),
      .rowHit_c   (rowHit_c),
      .anyOpen_c  (anyOpen_c)
   );

   // Next state and per-cycle strobes; row_resolve/ram_wait mark the deciding cycle
   always_comb begin
      ncmd_state   = cmd_state;
      row_resolve  = 1'b0;
      ram_wait     = 1'b1;
      openEn       = 1'b0;
      closeEn      = 1'b0;
      startAccess  = 1'b0;
      startRefresh = 1'b0;
      case (cmd_state)
         POWER_UP: if (tdone) ncmd_state = IDLE;
         IDLE: begin
            if (rf_req) begin
               startRefresh = 1'b1;
               ncmd_state   = anyOpen_c ? PRE_ALL : REFRESH;
            end else if (dREN || dWEN) begin
               startAccess = 1'b1;
               if (!bankOpen_c) begin
                  ncmd_state = ACTIVATE;
               end else if (!rowHit_c) begin
                  ncmd_state = PRECHARGE;
               end else begin
                  ncmd_state  = dREN ? READ : WRITE;
                  row_resolve = 1'b1;
               end
            end
         end
         ACTIVATE: if (tdone) begin
            ncmd_state  = accessRd ? READ : WRITE;
            row_resolve = 1'b1;
            openEn      = 1'b1;
         end
         READ, WRITE: if (tdone) begin
            ncmd_state = IDLE;
            ram_wait   = 1'b0;
         end
         PRECHARGE: if (tdone) begin
            ncmd_state = ACTIVATE;
            closeEn    = 1'b1;
         end
         PRE_ALL: if (tdone) ncmd_state = REFRESH;
         REFRESH: if (tdone) ncmd_state = IDLE;
         default: ncmd_state = POWER_UP;
      endcase
   end

   // Timing value loaded on entry to each state
   always_comb begin
      tload = CNT_W'(1);
      case (ncmd_state)
         POWER_UP:           tload = CNT_W'(T_INIT);
         ACTIVATE:           tload = CNT_W'(T_RCD);
         READ:               tload = CNT_W'(T_CL);
         WRITE:              tload = CNT_W'(T_WR);
         PRECHARGE, PRE_ALL: tload = CNT_W'(T_RP);
         REFRESH:            tload = CNT_W'(T_RFC);
         default:            tload = CNT_W'(1);
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) cmd_state <= POWER_UP;
      else     cmd_state <= ncmd_state;
   end

   // Counter, latched access context and init flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         tcnt      <= CNT_W'(T_INIT);
         cmd_bank  <= '0;
         accessRd  <= 1'b0;
         init_done <= 1'b0;
      end else begin
         if (ncmd_state != cmd_state) tcnt <= tload;
         else if (tcnt > CNT_W'(1))   tcnt <= tcnt - CNT_W'(1);
         if (startAccess) begin
            cmd_bank <= req_bank;
            accessRd <= dREN;
         end else if (startRefresh) begin
            cmd_bank <= '0;
         end
         if ((cmd_state == POWER_UP) && (ncmd_state == IDLE)) init_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dram_cmd_fsm_mb.sv
// Directed bench for dram_cmd_fsm_mb with hand-computed cycle expectations.
module tb_dram_cmd_fsm_mb;
   import dram_pkg::*;

   logic        CLK;
   logic        RST;
   logic        dREN;
   logic        dWEN;
   logic [1:0]  req_bank;
   logic [13:0] req_row;
   logic        rf_req;
   dram_state_t cmd_state;
   dram_state_t ncmd_state;
   logic [1:0]  cmd_bank;
   logic        init_done;
   logic        row_resolve;
   logic        ram_wait;

   int nCmp = 0;
   int nErr = 0;

   dram_cmd_fsm_mb dut (
      .CLK         (CLK),
      .RST         (RST),
      .dREN        (dREN),
      .dWEN        (dWEN),
      .req_bank    (req_bank),
      .req_row     (req_row),
      .rf_req      (rf_req),
      .cmd_state   (cmd_state),
      .ncmd_state  (ncmd_state),
      .cmd_bank    (cmd_bank),
      .init_done   (init_done),
      .row_resolve (row_resolve),
      .ram_wait    (ram_wait)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; dREN = 1'b0; dWEN = 1'b0; rf_req = 1'b0;
      req_bank = 2'd0; req_row = 14'h0;
      step(3);
      chk("rst_state",    32'(cmd_state), 32'(POWER_UP));
      chk("rst_init",     32'(init_done), 32'd0);
      chk("rst_wait",     32'(ram_wait), 32'd1);
      chk("rst_resolve",  32'(row_resolve), 32'd0);
      chk("rst_bank",     32'(cmd_bank), 32'd0);

      // Power-up: request at cycle 50 ignored, init after 200 cycles
      RST = 1'b0;
      step(50);
      dREN = 1'b1; req_bank = 2'd2; #1;
      chk("pu_ign_next",  32'(ncmd_state), 32'(POWER_UP));
      step(1);
      chk("pu_ign_state", 32'(cmd_state), 32'(POWER_UP));
      chk("pu_ign_wait",  32'(ram_wait), 32'd1);
      dREN = 1'b0; req_bank = 2'd0;
      step(148);
      chk("pu_199_init",  32'(init_done), 32'd0);
      chk("pu_199_next",  32'(ncmd_state), 32'(IDLE));
      step(1);
      chk("pu_200_init",  32'(init_done), 32'd1);
      chk("pu_200_state", 32'(cmd_state), 32'(IDLE));
      chk("idle_wait",    32'(ram_wait), 32'd1);

      // Read from all-closed: ACTIVATE 3, READ 4
      dREN = 1'b1; req_bank = 2'd1; req_row = 14'h12; #1;
      chk("rd1_next",     32'(ncmd_state), 32'(ACTIVATE));
      chk("rd1_nores",    32'(row_resolve), 32'd0);
      step(1);
      chk("rd1_act",      32'(cmd_state), 32'(ACTIVATE));
      chk("rd1_bank",     32'(cmd_bank), 32'd1);
      step(2);
      chk("rd1_res",      32'(row_resolve), 32'd1);
      chk("rd1_tord",     32'(ncmd_state), 32'(READ));
      step(1);
      chk("rd1_c4",       32'(cmd_state), 32'(READ));
      chk("rd1_c4_wait",  32'(ram_wait), 32'd1);
      step(3);
      chk("rd1_c7",       32'(cmd_state), 32'(READ));
      chk("rd1_c7_wait",  32'(ram_wait), 32'd0);
      dREN = 1'b0;
      step(1);
      chk("rd1_idle",     32'(cmd_state), 32'(IDLE));
      chk("rd1_idle_w",   32'(ram_wait), 32'd1);

      // Row hit: straight to READ, resolve in IDLE exit cycle
      dREN = 1'b1; #1;
      chk("hit_next",     32'(ncmd_state), 32'(READ));
      chk("hit_res",      32'(row_resolve), 32'd1);
      step(1);
      chk("hit_rd",       32'(cmd_state), 32'(READ));
      chk("hit_nores",    32'(row_resolve), 32'd0);
      step(2);
      chk("hit_c3_wait",  32'(ram_wait), 32'd1);
      step(1);
      chk("hit_c4_wait",  32'(ram_wait), 32'd0);
      dREN = 1'b0;
      step(1);
      chk("hit_idle",     32'(cmd_state), 32'(IDLE));

      // Row miss write: PRECHARGE 3, ACTIVATE 3, WRITE 4
      dWEN = 1'b1; req_row = 14'h34; #1;
      chk("wr_next",      32'(ncmd_state), 32'(PRECHARGE));
      chk("wr_nores",     32'(row_resolve), 32'd0);
      step(1);
      chk("wr_pre",       32'(cmd_state), 32'(PRECHARGE));
      step(2);
      chk("wr_toact",     32'(ncmd_state), 32'(ACTIVATE));
      step(1);
      chk("wr_act",       32'(cmd_state), 32'(ACTIVATE));
      step(2);
      chk("wr_res",       32'(row_resolve), 32'd1);
      chk("wr_towr",      32'(ncmd_state), 32'(WRITE));
      step(1);
      chk("wr_c7",        32'(cmd_state), 32'(WRITE));
      step(3);
      chk("wr_c10",       32'(cmd_state), 32'(WRITE));
      chk("wr_c10_wait",  32'(ram_wait), 32'd0);
      dWEN = 1'b0;
      step(1);
      chk("wr_idle",      32'(cmd_state), 32'(IDLE));

      // Refresh requested mid-read with banks 0 and 1 open
      dREN = 1'b1; req_bank = 2'd0; req_row = 14'h5; #1;
      chk("rf_rd_next",   32'(ncmd_state), 32'(ACTIVATE));
      step(4);
      chk("rf_rd_c4",     32'(cmd_state), 32'(READ));
      rf_req = 1'b1; #1;
      chk("rf_noabort",   32'(ncmd_state), 32'(READ));
      step(3);
      chk("rf_rd_c7",     32'(cmd_state), 32'(READ));
      chk("rf_rd_wait",   32'(ram_wait), 32'd0);
      dREN = 1'b0;
      step(1);
      chk("rf_idle",      32'(cmd_state), 32'(IDLE));
      chk("rf_topreall",  32'(ncmd_state), 32'(PRE_ALL));
      step(1);
      chk("rf_preall",    32'(cmd_state), 32'(PRE_ALL));
      chk("rf_pa_bank",   32'(cmd_bank), 32'd0);
      step(2);
      chk("rf_torefr",    32'(ncmd_state), 32'(REFRESH));
      step(1);
      chk("rf_refr",      32'(cmd_state), 32'(REFRESH));
      chk("rf_rf_bank",   32'(cmd_bank), 32'd0);
      rf_req = 1'b0;
      step(15);
      chk("rf_c16",       32'(cmd_state), 32'(REFRESH));
      chk("rf_toidle",    32'(ncmd_state), 32'(IDLE));
      step(1);
      chk("rf_done",      32'(cmd_state), 32'(IDLE));
      dREN = 1'b1; req_bank = 2'd1; req_row = 14'h34; #1;
      chk("rf_b1_closed", 32'(ncmd_state), 32'(ACTIVATE));
      req_bank = 2'd0; req_row = 14'h5; #1;
      chk("rf_b0_closed", 32'(ncmd_state), 32'(ACTIVATE));

      // Open bank 2 row 7 before the reset test
      req_bank = 2'd2; req_row = 14'h7; #1;
      step(7);
      chk("b2_rd_wait",   32'(ram_wait), 32'd0);
      dREN = 1'b0;
      step(1);
      chk("b2_idle",      32'(cmd_state), 32'(IDLE));

      // Reset during cycle 2 of ACTIVATE
      dREN = 1'b1; req_bank = 2'd0; req_row = 14'h5;
      step(2);
      chk("mr_act_c2",    32'(cmd_state), 32'(ACTIVATE));
      RST = 1'b1; dREN = 1'b0;
      step(1);
      chk("mr_state",     32'(cmd_state), 32'(POWER_UP));
      chk("mr_init",      32'(init_done), 32'd0);
      chk("mr_wait",      32'(ram_wait), 32'd1);
      chk("mr_bank",      32'(cmd_bank), 32'd0);
      RST = 1'b0;
      step(199);
      chk("mr_199_state", 32'(cmd_state), 32'(POWER_UP));
      step(1);
      chk("mr_200_state", 32'(cmd_state), 32'(IDLE));
      chk("mr_200_init",  32'(init_done), 32'd1);

      // No bank open: refresh goes direct and wins over a read
      rf_req = 1'b1; dREN = 1'b1; req_bank = 2'd2; req_row = 14'h7; #1;
      chk("rfd_next",     32'(ncmd_state), 32'(REFRESH));
      step(1);
      rf_req = 1'b0;
      chk("rfd_state",    32'(cmd_state), 32'(REFRESH));
      step(15);
      chk("rfd_toidle",   32'(ncmd_state), 32'(IDLE));
      step(1);
      chk("rfd_idle",     32'(cmd_state), 32'(IDLE));

      // dREN&dWEN treated as read; bank 2 closed by reset
      dWEN = 1'b1; #1;
      chk("rw_next",      32'(ncmd_state), 32'(ACTIVATE));
      step(3);
      chk("rw_tord",      32'(ncmd_state), 32'(READ));
      step(1);
      chk("rw_rd",        32'(cmd_state), 32'(READ));
      step(3);
      chk("rw_wait",      32'(ram_wait), 32'd0);
      dREN = 1'b0; dWEN = 1'b0;
      step(1);
      chk("rw_idle",      32'(cmd_state), 32'(IDLE));

      // Refresh with a bank open goes through PRE_ALL
      rf_req = 1'b1; #1;
      chk("rfo_next",     32'(ncmd_state), 32'(PRE_ALL));
      rf_req = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule

// File: doc/dram_cmd_fsm_mb.md
DRAM_CMD_FSM_MB -- requirements
Module: dram_cmd_fsm_mb

Interface
REQ-001 SHALL have parameter NBANK, default 4, number of banks tracked (power of 2, ≥2).
REQ-002 SHALL have parameter ROW_W, default 14, row address width.
REQ-003 SHALL have parameters T_INIT=200, T_RCD=3, T_RP=3, T_CL=4, T_WR=4, T_RFC=16, cycle counts (each ≥1).
REQ-004 SHALL have port CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port dREN  in  1  read request, level, held until ram_wait low.
REQ-007 SHALL have port dWEN  in  1  write request, level; dREN&dWEN treated as read.
REQ-008 SHALL have port req_bank  in  $clog2(NBANK)  target bank, stable while request held.
REQ-009 SHALL have port req_row  in  ROW_W  target row, stable while request held.
REQ-010 SHALL have port rf_req  in  1  refresh request, level, held until refresh starts.
REQ-011 SHALL have port cmd_state  out  dram_state_t  current registered state.
REQ-012 SHALL have port ncmd_state  out  dram_state_t  combinational next state.
REQ-013 SHALL have port cmd_bank  out  $clog2(NBANK)  bank addressed by current command.
REQ-014 SHALL have port init_done  out  1  high once power-up wait complete; stays high.
REQ-015 SHALL have port row_resolve  out  1  one-cycle pulse when target row becomes/is open.
REQ-016 SHALL have port ram_wait  out  1  low for exactly one cycle per completed access.

Function
REQ-017 States: POWER_UP, IDLE, ACTIVATE, READ, WRITE, PRECHARGE, PRE_ALL, REFRESH.
REQ-018 Internal down-counter tcnt loads state's timing value on state entry (ACTIVATE=T_RCD, READ=T_CL, WRITE=T_WR, PRECHARGE/PRE_ALL=T_RP, REFRESH=T_RFC, POWER_UP=T_INIT); state exits in the cycle tcnt==1.
REQ-019 Per bank: open flag and ROW_W-bit open_row register.
REQ-020 POWER_UP -> IDLE on expiry; init_done set in the IDLE-entry cycle; requests ignored before then.
REQ-021 IDLE priority: rf_req over dREN/dWEN.
REQ-022 IDLE + rf_req: any bank open -> PRE_ALL -> REFRESH; none open -> REFRESH directly; REFRESH -> IDLE.
REQ-023 IDLE + request, bank open, row match (hit): -> READ/WRITE directly; row_resolve pulses that cycle.
REQ-024 Bank closed: -> ACTIVATE -> READ/WRITE; bank marked open with req_row at ACTIVATE exit; row_resolve pulses then.
REQ-025 Bank open, row mismatch: -> PRECHARGE (clears that bank's open flag on exit) -> ACTIVATE -> READ/WRITE.
REQ-026 READ/WRITE exit: -> IDLE, ram_wait low that cycle only; bank stays open (open-page policy).
REQ-027 ram_wait high in every other cycle, including IDLE with no request.
REQ-028 rf_req asserted mid-access SHALL NOT abort; serviced at next IDLE.
REQ-029 PRE_ALL/REFRESH clear all open flags; cmd_bank holds 0 in these states.
REQ-030 cmd_bank latches req_bank on leaving IDLE for an access, holds until return to IDLE.
REQ-031 Request changes while not in IDLE are ignored (caller protocol violation).

Reset
REQ-032 RST high at any clock edge, including mid-access or mid-refresh: cmd_state=POWER_UP, tcnt=T_INIT, all open flags 0, open_row 0, cmd_bank 0, init_done 0, row_resolve 0, ram_wait 1; power-up wait restarts.

Structure
REQ-033 dram_state_t and default timing constants SHALL live in dram_pkg.
REQ-034 Bank table (open flags, rows, hit compare) SHALL be sub-module dram_bank_tracker; FSM and tcnt in dram_cmd_fsm_mb.

Verification
REQ-035 Reset release, idle -> init_done rises after 200 cycles; dREN at cycle 50 unanswered.
REQ-036 Read bank 1 row 0x12 from all-closed -> ACTIVATE 3 cycles, READ 4, ram_wait low at cycle 7 after leaving IDLE.
REQ-037 Repeat read bank 1 row 0x12 -> hit, row_resolve same cycle IDLE exits, ram_wait low after 4 READ cycles.
REQ-038 Write bank 1 row 0x34 -> PRECHARGE 3, ACTIVATE 3, WRITE 4; ram_wait low at cycle 10.
REQ-039 rf_req during READ with banks 0,1 open -> READ completes, PRE_ALL 3, REFRESH 16, all flags cleared, next access to bank 0 activates.
REQ-040 RST asserted in cycle 2 of ACTIVATE -> next cycle POWER_UP, init_done 0, ram_wait 1, all banks closed.
